// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue stage with register busy scoreboard and halt drain
module issue_scoreboard #(
  parameter int NUM_FU   = 8,
  parameter int NUM_REGS = 32,
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0][4:0]              in_readregs,
  input  logic [4:0]                   in_writereg,
  input  logic [7:0]                   in_flags,
  input  logic [3:0]                   in_fuid,
  input  logic                         in_halt,
  input  logic                         flush,
  output logic [NUM_FU-1:0]            fu_valid,
  input  logic [NUM_FU-1:0]            fu_ready,
  output logic [1:0][4:0]              fu_readregs,
  output logic [4:0]                   fu_writereg,
  output logic [7:0]                   fu_flags,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS-1:0][4:0]     wb_reg,
  output logic                         halted,
  output logic                         illegal_fu,
  output logic [CNT_W-1:0]             stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                hold_valid_q, hold_valid_d;
  logic [1:0][4:0]     hold_rs_q, hold_rs_d;
  logic [4:0]          hold_wr_q, hold_wr_d;
  logic [7:0]          hold_flags_q, hold_flags_d;
  logic [3:0]          hold_fuid_q, hold_fuid_d;
  logic                hold_halt_q, hold_halt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] busy_eff;
  logic                hazard;
  logic                run;
  logic                fu_legal;
  logic                fu_bad;
  logic                go;
  logic                sel_ready;
  logic                issue;
  logic                transfer;
  logic                halt_take;
  logic                accept;

  // Hazard check with same-cycle writeback bypass and issue handshake decode
  always_comb begin
    wb_clear = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) wb_clear[wb_reg[p]] = 1'b1;
    end
    busy_eff    = busy_q & ~wb_clear;
    busy_eff[0] = 1'b0;
    hazard = busy_eff[hold_rs_q[0]] | busy_eff[hold_rs_q[1]] | busy_eff[hold_wr_q];

    run      = (state_q == S_RUN);
    fu_legal = (hold_fuid_q != 4'd0) && (int'(hold_fuid_q) < NUM_FU);
    fu_bad   = (int'(hold_fuid_q) >= NUM_FU);
    go       = run & hold_valid_q & ~hold_halt_q & ~hazard & ~flush;

    fu_valid  = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_fuid_q == 4'(i)) begin
        fu_valid[i] = go & fu_legal;
        sel_ready   = fu_ready[i];
      end
    end

    // noop and out-of-range FU ids retire in place without a handshake
    issue     = go & (fu_legal ? sel_ready : 1'b1);
    transfer  = go & fu_legal & sel_ready;
    halt_take = run & hold_valid_q & hold_halt_q & ~flush;
    in_ready  = run & ~flush & (~hold_valid_q | issue);
    accept    = in_valid & in_ready;
  end

  // Next-state for FSM, holding register, scoreboard and status
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_rs_d    = hold_rs_q;
    hold_wr_d    = hold_wr_q;
    hold_flags_d = hold_flags_q;
    hold_fuid_d  = hold_fuid_q;
    hold_halt_d  = hold_halt_q;
    illegal_d    = illegal_q;
    stall_d      = stall_q;

    // set after clear so a same-edge set on the same tag wins
    busy_d = busy_q & ~wb_clear;
    if (transfer && hold_wr_q != 5'd0) busy_d[hold_wr_q] = 1'b1;
    busy_d[0] = 1'b0;

    case (state_q)
      S_RUN: begin
        if (halt_take) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (flush) state_d = S_RUN;
        else if (busy_eff == '0) state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase

    if (state_q != S_HALTED && flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_rs_d    = in_readregs;
      hold_wr_d    = in_writereg;
      hold_flags_d = in_flags;
      hold_fuid_d  = in_fuid;
      hold_halt_d  = in_halt;
    end else if (issue || halt_take) begin
      hold_valid_d = 1'b0;
    end

    if (issue && fu_bad) illegal_d = 1'b1;

    if (run && hold_valid_q && !issue && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      hold_valid_q <= 1'b0;
      hold_rs_q    <= '0;
      hold_wr_q    <= '0;
      hold_flags_q <= '0;
      hold_fuid_q  <= '0;
      hold_halt_q  <= 1'b0;
      busy_q       <= '0;
      illegal_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_rs_q    <= hold_rs_d;
      hold_wr_q    <= hold_wr_d;
      hold_flags_q <= hold_flags_d;
      hold_fuid_q  <= hold_fuid_d;
      hold_halt_q  <= hold_halt_d;
      busy_q       <= busy_d;
      illegal_q    <= illegal_d;
      stall_q      <= stall_d;
    end
  end

  assign fu_readregs = hold_rs_q;
  assign fu_writereg = hold_wr_q;
  assign fu_flags    = hold_flags_q;
  assign halted      = (state_q == S_HALTED);
  assign illegal_fu  = illegal_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0][4:0] in_readregs;
  logic [4:0]      in_writereg;
  logic [7:0]      in_flags;
  logic [3:0]      in_fuid;
  logic            in_halt;
  logic            flush;
  logic [7:0]      fu_valid;
  logic [7:0]      fu_ready;
  logic [1:0][4:0] fu_readregs;
  logic [4:0]      fu_writereg;
  logic [7:0]      fu_flags;
  logic [1:0]      wb_valid;
  logic [1:0][4:0] wb_reg;
  logic            halted;
  logic            illegal_fu;
  logic [15:0]     stall_cnt;

  typedef struct {
    logic [3:0]      fuid;
    logic [1:0][4:0] rs;
    logic [4:0]      wr;
    logic [7:0]      flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_readregs(in_readregs), .in_writereg(in_writereg),
    .in_flags(in_flags), .in_fuid(in_fuid), .in_halt(in_halt),
    .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_readregs(fu_readregs), .fu_writereg(fu_writereg), .fu_flags(fu_flags),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .halted(halted), .illegal_fu(illegal_fu), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] wr,
                        input logic [3:0] fuid, input logic [7:0] flags,
                        input logic halt, input bit push);
    exp_t e;
    in_readregs[0] = rs0;
    in_readregs[1] = rs1;
    in_writereg    = wr;
    in_fuid        = fuid;
    in_flags       = flags;
    in_halt        = halt;
    in_valid       = 1'b1;
    #1;
    chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_halt  = 1'b0;
    if (push) begin
      e.fuid  = fuid;
      e.rs[0] = rs0;
      e.rs[1] = rs1;
      e.wr    = wr;
      e.flags = flags;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_issue(input string tag);
    exp_t       e;
    logic [7:0] ev;
    #1;
    chk({tag, "_pending"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = 8'd1 << e.fuid;
      chk({tag, "_fu_valid"},    {24'd0, fu_valid},    {24'd0, ev});
      chk({tag, "_fu_readregs"}, {22'd0, fu_readregs}, {22'd0, e.rs});
      chk({tag, "_fu_writereg"}, {27'd0, fu_writereg}, {27'd0, e.wr});
      chk({tag, "_fu_flags"},    {24'd0, fu_flags},    {24'd0, e.flags});
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_readregs = '0; in_writereg = '0;
    in_flags = '0; in_fuid = '0; in_halt = 1'b0; flush = 1'b0;
    fu_ready = 8'hFF; wb_valid = '0; wb_reg = '0;

    // reset state
    #3;
    chk("rst_fu_valid",   {24'd0, fu_valid}, 32'd0);
    chk("rst_halted",     {31'd0, halted}, 32'd0);
    chk("rst_illegal",    {31'd0, illegal_fu}, 32'd0);
    chk("rst_stall",      {16'd0, stall_cnt}, 32'd0);
    chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // add r3 <- r1, r5 on fuid 1, then dependent instr on r3 back to back
    accept(5'd1, 5'd5, 5'd3, 4'd1, 8'h11, 1'b0, 1'b1);
    expect_issue("add_r3");
    accept(5'd3, 5'd0, 5'd4, 4'd2, 8'h22, 1'b0, 1'b1);
    #1;
    chk("raw_fu_valid", {24'd0, fu_valid}, 32'd0);
    chk("raw_in_ready", {31'd0, in_ready}, 32'd0);
    chk("raw_stall0",   {16'd0, stall_cnt}, 32'(exp_stall));
    tick(); exp_stall++;
    tick(); exp_stall++;
    chk("raw_stall2", {16'd0, stall_cnt}, 32'(exp_stall));
    wb_valid = 2'b01; wb_reg[0] = 5'd3;
    expect_issue("raw_bypass");
    chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 2'b00;
    chk("raw_stall_hold", {16'd0, stall_cnt}, 32'(exp_stall));

    // set wins over clear on r7
    accept(5'd0, 5'd0, 5'd7, 4'd1, 8'h31, 1'b0, 1'b1);
    expect_issue("w_r7");
    tick();
    accept(5'd0, 5'd0, 5'd7, 4'd3, 8'h32, 1'b0, 1'b1);
    #1;
    chk("waw_stall", {24'd0, fu_valid}, 32'd0);
    tick(); exp_stall++;
    wb_valid = 2'b01; wb_reg[0] = 5'd7;
    expect_issue("waw_bypass");
    tick();
    wb_valid = 2'b00;
    accept(5'd7, 5'd0, 5'd0, 4'd1, 8'h33, 1'b0, 1'b1);
    #1;
    chk("set_wins_r7", {24'd0, fu_valid}, 32'd0);
    tick(); exp_stall++;
    wb_valid = 2'b11; wb_reg[0] = 5'd7; wb_reg[1] = 5'd4;
    expect_issue("read_r7");
    tick();
    wb_valid = 2'b00;

    // FU backpressure for 3 cycles
    fu_ready = 8'hDF;
    accept(5'd2, 5'd6, 5'd9, 4'd5, 8'hA5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_fu_valid",    {24'd0, fu_valid}, 32'h20);
      chk("bp_fu_writereg", {27'd0, fu_writereg}, 32'd9);
      chk("bp_fu_flags",    {24'd0, fu_flags}, 32'hA5);
      tick(); exp_stall++;
    end
    fu_ready = 8'hFF;
    expect_issue("bp_release");
    tick();
    chk("bp_stall", {16'd0, stall_cnt}, 32'(exp_stall));

    // halt drains while r5 busy
    accept(5'd0, 5'd0, 5'd5, 4'd1, 8'h41, 1'b0, 1'b1);
    wb_valid = 2'b01; wb_reg[0] = 5'd9;
    expect_issue("w_r5");
    tick();
    wb_valid = 2'b00;
    accept(5'd0, 5'd0, 5'd0, 4'd0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("halt_fu_valid", {24'd0, fu_valid}, 32'd0);
    tick();
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_halted",   {31'd0, halted}, 32'd0);
    tick();
    chk("drain_halted2", {31'd0, halted}, 32'd0);
    wb_valid = 2'b01; wb_reg[0] = 5'd5;
    #1;
    chk("drain_wb_halted", {31'd0, halted}, 32'd0);
    tick();
    wb_valid = 2'b00;
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halted_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    #1;
    chk("halted_flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("halted_after_flush", {31'd0, halted}, 32'd1);
    chk("halted_fu_valid",    {24'd0, fu_valid}, 32'd0);

    // reset clears everything
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_stall",  {16'd0, stall_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    exp_stall = 0;

    // illegal fuid retires in place without busy set
    accept(5'd0, 5'd0, 5'd12, 4'd1, 8'h51, 1'b0, 1'b1);
    expect_issue("w_r12");
    tick();
    accept(5'd0, 5'd0, 5'd13, 4'hA, 8'h52, 1'b0, 1'b0);
    #1;
    chk("illegal_fu_valid", {24'd0, fu_valid}, 32'd0);
    chk("illegal_pre",      {31'd0, illegal_fu}, 32'd0);
    chk("illegal_ready",    {31'd0, in_ready}, 32'd1);
    tick();
    chk("illegal_set", {31'd0, illegal_fu}, 32'd1);
    accept(5'd13, 5'd0, 5'd0, 4'd1, 8'h53, 1'b0, 1'b1);
    expect_issue("r13_not_busy");
    tick();

    // flush while holding keeps busy bits
    accept(5'd12, 5'd0, 5'd0, 4'd2, 8'h54, 1'b0, 1'b1);
    #1;
    chk("flush_pre_fu_valid", {24'd0, fu_valid}, 32'd0);
    flush = 1'b1;
    #1;
    chk("flush_fu_valid", {24'd0, fu_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); exp_stall++;
    flush = 1'b0;
    void'(exp_q.pop_front());
    #1;
    chk("flush_hold_gone", {24'd0, fu_valid}, 32'd0);
    chk("illegal_sticky",  {31'd0, illegal_fu}, 32'd1);
    accept(5'd12, 5'd0, 5'd0, 4'd1, 8'h55, 1'b0, 1'b1);
    #1;
    chk("busy12_kept", {24'd0, fu_valid}, 32'd0);
    tick(); exp_stall++;
    wb_valid = 2'b10; wb_reg[1] = 5'd12;
    expect_issue("r12_release");
    tick();
    wb_valid = 2'b00;
    chk("final_stall", {16'd0, stall_cnt}, 32'(exp_stall));
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
